data_mem_arbiter: RTL and testbench
===================================

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset: clock  in  1  rising-edge clock shared with DataMemory; reset  in  1  asynchronous, active-high.
REQ-002 Port 0 requester (CPU) SHALL have: req0  in  1  request; we0  in  1  1=write/0=read; addr0  in  32  word address; wdata0  in  32  write data; gnt0  out  1  request accepted this cycle; done0  out  1  access complete; rdata0  out  32  registered read data.
REQ-003 Port 1 requester (loader/debug) SHALL have the same signal set with suffix 1: req1, we1, addr1, wdata1, gnt1, done1, rdata1.
REQ-004 Memory side SHALL have: mem_addr  out  32  to read_write_addr; mem_wdata  out  32  to write_data; mem_we  out  1  to MemWrite; mem_rdata  in  32  from read_data (combinational read, write on rising clock edge).
REQ-005 Status SHALL be: busy  out  1  high while state is ACCESS; last_port  out  1  index of the port most recently granted.

Function
REQ-006 The FSM SHALL have two states: IDLE and ACCESS.
REQ-007 In IDLE, at a rising edge with req0|req1 high, the block SHALL select a winner, latch its we/addr/wdata into internal registers, enter ACCESS, and set gnt of the winner high for exactly the following cycle.
REQ-008 Arbitration SHALL be round-robin: with one request, that port wins; with both, the port not equal to last_port wins.
REQ-009 In ACCESS, mem_addr, mem_wdata and mem_we SHALL be driven from the latched registers only; in IDLE, mem_we SHALL be 0 and mem_addr/mem_wdata SHALL hold their last values.
REQ-010 At the rising edge ending an ACCESS cycle, the block SHALL load rdata of the served port with mem_rdata (reads only; writes leave rdata unchanged), pulse that port's done high for one cycle, and update last_port.
REQ-011 Latency SHALL be: req sampled at edge N -> gnt and memory access in cycle N..N+1 -> done and rdata valid in cycle N+1..N+2.
REQ-012 A requester SHALL hold req, we, addr and wdata stable until the edge at which its gnt is high; a req still high at that edge is a new request.
REQ-013 At the edge ending ACCESS, if any req is high, the block SHALL arbitrate per REQ-008 and remain in ACCESS (back-to-back, one access per cycle); otherwise it SHALL return to IDLE.
REQ-014 gnt0 and gnt1 SHALL never be high together; done0 and done1 SHALL never be high together.
REQ-015 A write followed by a read of the same address SHALL return the written value, since the write commits at the edge ending its ACCESS cycle.
REQ-016 A request whose req drops before being sampled SHALL be discarded without gnt or done.

Reset
REQ-017 While reset is high, state SHALL be IDLE, and gnt0/1, done0/1, mem_we and busy SHALL be 0.
REQ-018 While reset is high, rdata0/1, mem_addr and mem_wdata SHALL be 0.
REQ-019 While reset is high, last_port SHALL be 1, so port 0 wins the first tie.
REQ-020 Reset asserted during ACCESS SHALL clear mem_we immediately, so no write commits, and no done pulse SHALL follow.

Verification
REQ-021 After reset, req0=1 we0=1 addr0=1 wdata0=16 for one cycle -> gnt0 next cycle with mem_we=1 mem_addr=1; done0 the cycle after; word 1 holds 16.
REQ-022 req0 and req1 asserted together in the same cycle: port 0 writes addr 3=27, port 1 reads addr 3 -> gnt0 first, then gnt1 back-to-back; rdata1=27 with done1; busy high for 2 cycles.
REQ-023 req0 and req1 held high for 6 cycles -> grants alternate 0,1,0,1,0,1 with no idle cycle; never simultaneous.
REQ-024 Port 1 reads addr 2 (never written) -> rdata1 = DataMemory's initial content of word 2; rdata0 unchanged.
REQ-025 Reset pulsed mid-ACCESS of a write of 99 to addr 5 -> mem_we falls immediately; word 5 unchanged; no done; next tie grants port 0.
REQ-026 req1 pulsed for half a cycle between edges -> no gnt1, no done1, busy stays 0.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory.
// One access per cycle; grants, done pulses, read data and memory controls are all registered.
module data_mem_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0,
  input  logic        we0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  output logic        gnt0,
  output logic        done0,
  output logic [31:0] rdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic        gnt1,
  output logic        done1,
  output logic [31:0] rdata1,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        last_port
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state_q, state_d;
  logic        served_q, served_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        mem_we_q, mem_we_d;
  logic        gnt0_q, gnt0_d;
  logic        gnt1_q, gnt1_d;
  logic        done0_q, done0_d;
  logic        done1_q, done1_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic        last_port_q, last_port_d;

  logic        arb_last;
  logic        any_req;
  logic        winner;

  // Back-to-back arbitration must see the port finishing now as the most recent one.
  always_comb begin
    arb_last = (state_q == ACCESS) ? served_q : last_port_q;
    any_req  = req0 | req1;
    winner   = (req0 & req1) ? ~arb_last : req1;
  end

  always_comb begin
    state_d     = state_q;
    served_d    = served_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mem_we_d    = 1'b0;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    done0_d     = 1'b0;
    done1_d     = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    last_port_d = last_port_q;

    if (state_q == ACCESS) begin
      done0_d     = ~served_q;
      done1_d     = served_q;
      last_port_d = served_q;
      if (!mem_we_q) begin
        if (served_q) rdata1_d = mem_rdata;
        else          rdata0_d = mem_rdata;
      end
    end

    if (any_req) begin
      state_d  = ACCESS;
      served_d = winner;
      addr_d   = winner ? addr1  : addr0;
      wdata_d  = winner ? wdata1 : wdata0;
      mem_we_d = winner ? we1    : we0;
      gnt0_d   = ~winner;
      gnt1_d   = winner;
    end else begin
      state_d  = IDLE;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      served_q    <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      mem_we_q    <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      rdata0_q    <= 32'd0;
      rdata1_q    <= 32'd0;
      last_port_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      served_q    <= served_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mem_we_q    <= mem_we_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      last_port_q <= last_port_d;
    end
  end

  // Address and data keep their last values while idle; only the write enable drops.
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = mem_we_q;
  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign busy      = (state_q == ACCESS);
  assign last_port = last_port_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed vector table, reset/glitch sequences, and
// randomized two-port traffic checked against a transaction-level model.
module tb_data_mem_arbiter;

  logic        clock;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        gnt0, done0, gnt1, done1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, busy, last_port;

  int checks = 0;
  int errors = 0;

  data_mem_arbiter dut (
    .clock(clock), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .done0(done0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .done1(done1), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .busy(busy), .last_port(last_port)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // DataMemory stand-in: combinational read, write on rising edge, known initial content.
  logic [31:0] dmem [0:255];
  logic        mem_init;
  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) dmem[i] <= 32'hA000 + i;
    end else if (mem_we) begin
      dmem[mem_addr[7:0]] <= mem_wdata;
    end
  end
  assign mem_rdata = dmem[mem_addr[7:0]];

  typedef struct {
    logic        rst, r0, w0;
    logic [31:0] a0, d0;
    logic        r1, w1;
    logic [31:0] a1, d1;
    logic        g0, g1, dn0, dn1, bsy, mwe;
    logic [31:0] maddr, rd0, rd1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic rst, input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
    input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
    input logic g0, input logic g1, input logic dn0, input logic dn1, input logic bsy,
    input logic mwe, input logic [31:0] maddr, input logic [31:0] rd0, input logic [31:0] rd1);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.dn0 = dn0; v.dn1 = dn1; v.bsy = bsy; v.mwe = mwe;
    v.maddr = maddr; v.rd0 = rd0; v.rd1 = rd1;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    reset = v.rst;
    req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0;
    req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1;
  endtask

  task automatic idle_inputs();
    req0 = 1'b0; we0 = 1'b0; addr0 = 32'd0; wdata0 = 32'd0;
    req1 = 1'b0; we1 = 1'b0; addr1 = 32'd0; wdata1 = 32'd0;
  endtask

  // Transaction-level model: one memory operation in flight, round-robin on ties.
  logic        rq [2];
  logic        wq [2];
  logic [31:0] aq [2];
  logic [31:0] dq [2];
  logic [31:0] m_mem [0:7];
  logic [31:0] m_rdata [2];
  logic        e_gnt [2];
  logic        e_done [2];
  logic        m_busy, m_we;
  int          m_port, m_last;
  logic [31:0] m_addr, m_wdata;

  task automatic model_step();
    int w;
    e_gnt[0] = 1'b0; e_gnt[1] = 1'b0;
    e_done[0] = 1'b0; e_done[1] = 1'b0;
    if (m_busy) begin
      if (m_we) m_mem[m_addr[2:0]] = m_wdata;
      else      m_rdata[m_port] = m_mem[m_addr[2:0]];
      e_done[m_port] = 1'b1;
      m_last = m_port;
    end
    if (rq[0] || rq[1]) begin
      if (rq[0] && rq[1]) w = 1 - m_last;
      else                w = rq[1] ? 1 : 0;
      m_busy = 1'b1; m_port = w;
      m_we = wq[w]; m_addr = aq[w]; m_wdata = dq[w];
      e_gnt[w] = 1'b1;
    end else begin
      m_busy = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1;
    mem_init = 1'b1;
    idle_inputs();
    @(negedge clock);
    mem_init = 1'b0;

    // Single write, round-robin pair, never-written read, six-cycle contention.
    vecs.push_back(mk(1,0,0,0,0,   0,0,0,0,  0,0,0,0,0,0, 0, 0, 0));
    vecs.push_back(mk(0,1,1,1,16,  0,0,0,0,  1,0,0,0,1,1, 1, 0, 0));
    vecs.push_back(mk(0,0,0,0,0,   0,0,0,0,  0,0,1,0,0,0, 1, 0, 0));
    vecs.push_back(mk(0,0,0,0,0,   0,0,0,0,  0,0,0,0,0,0, 1, 0, 0));
    vecs.push_back(mk(1,0,0,0,0,   0,0,0,0,  0,0,0,0,0,0, 0, 0, 0));
    vecs.push_back(mk(0,1,1,3,27,  1,0,3,0,  1,0,0,0,1,1, 3, 0, 0));
    vecs.push_back(mk(0,0,0,0,0,   1,0,3,0,  0,1,1,0,1,0, 3, 0, 0));
    vecs.push_back(mk(0,0,0,0,0,   0,0,0,0,  0,0,0,1,0,0, 3, 0, 27));
    vecs.push_back(mk(0,0,0,0,0,   0,0,0,0,  0,0,0,0,0,0, 3, 0, 27));
    vecs.push_back(mk(0,0,0,0,0,   1,0,2,0,  0,1,0,0,1,0, 2, 0, 27));
    vecs.push_back(mk(0,0,0,0,0,   0,0,0,0,  0,0,0,1,0,0, 2, 0, 32'hA002));
    vecs.push_back(mk(0,0,0,0,0,   0,0,0,0,  0,0,0,0,0,0, 2, 0, 32'hA002));
    vecs.push_back(mk(0,1,0,4,0,   1,0,6,0,  1,0,0,0,1,0, 4, 0,        32'hA002));
    vecs.push_back(mk(0,1,0,4,0,   1,0,6,0,  0,1,1,0,1,0, 6, 32'hA004, 32'hA002));
    vecs.push_back(mk(0,1,0,4,0,   1,0,6,0,  1,0,0,1,1,0, 4, 32'hA004, 32'hA006));
    vecs.push_back(mk(0,1,0,4,0,   1,0,6,0,  0,1,1,0,1,0, 6, 32'hA004, 32'hA006));
    vecs.push_back(mk(0,1,0,4,0,   1,0,6,0,  1,0,0,1,1,0, 4, 32'hA004, 32'hA006));
    vecs.push_back(mk(0,1,0,4,0,   1,0,6,0,  0,1,1,0,1,0, 6, 32'hA004, 32'hA006));
    vecs.push_back(mk(0,0,0,0,0,   0,0,0,0,  0,0,0,1,0,0, 6, 32'hA004, 32'hA006));
    vecs.push_back(mk(0,0,0,0,0,   0,0,0,0,  0,0,0,0,0,0, 6, 32'hA004, 32'hA006));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      @(posedge clock);
      @(negedge clock);
      checkOutput($sformatf("v%0d_gnt0", i),  32'(gnt0),  32'(vecs[i].g0));
      checkOutput($sformatf("v%0d_gnt1", i),  32'(gnt1),  32'(vecs[i].g1));
      checkOutput($sformatf("v%0d_done0", i), 32'(done0), 32'(vecs[i].dn0));
      checkOutput($sformatf("v%0d_done1", i), 32'(done1), 32'(vecs[i].dn1));
      checkOutput($sformatf("v%0d_busy", i),  32'(busy),  32'(vecs[i].bsy));
      checkOutput($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].mwe));
      checkOutput($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].maddr);
      checkOutput($sformatf("v%0d_rdata0", i), rdata0, vecs[i].rd0);
      checkOutput($sformatf("v%0d_rdata1", i), rdata1, vecs[i].rd1);
    end
    checkOutput("word1_written", dmem[1], 32'd16);
    checkOutput("word3_written", dmem[3], 32'd27);

    // Reset in the middle of a write: nothing commits, no done, tie restarts at port 0.
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd0;
    @(posedge clock); @(negedge clock);
    req0 = 1'b0;
    @(posedge clock); @(negedge clock);
    checkOutput("pre_reset_last_port", 32'(last_port), 32'd0);
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'd5; wdata0 = 32'd99;
    @(posedge clock); #1;
    checkOutput("midrst_mem_we_before", 32'(mem_we), 32'd1);
    req0 = 1'b0;
    #1 reset = 1'b1;
    #1;
    checkOutput("midrst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("midrst_busy",   32'(busy),   32'd0);
    checkOutput("midrst_gnt0",   32'(gnt0),   32'd0);
    checkOutput("midrst_last_port", 32'(last_port), 32'd1);
    #1 reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clock); #1;
      checkOutput("midrst_no_done0", 32'(done0), 32'd0);
    end
    checkOutput("midrst_word5", dmem[5], 32'hA005);
    @(negedge clock);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'd1;
    @(posedge clock); #1;
    checkOutput("postrst_tie_gnt0", 32'(gnt0), 32'd1);
    checkOutput("postrst_tie_gnt1", 32'(gnt1), 32'd0);
    req0 = 1'b0;
    @(posedge clock); #1;
    checkOutput("postrst_then_gnt1", 32'(gnt1), 32'd1);
    req1 = 1'b0;
    @(negedge clock); @(negedge clock);

    // Half-cycle glitch on req1 between edges must vanish.
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'd7; wdata1 = 32'd5;
    #2 req1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      checkOutput("glitch_gnt1",  32'(gnt1),  32'd0);
      checkOutput("glitch_done1", 32'(done1), 32'd0);
      checkOutput("glitch_busy",  32'(busy),  32'd0);
    end
    checkOutput("glitch_word7", dmem[7], 32'hA007);

    // Randomized traffic on words 0..7 against the model.
    reset = 1'b1; mem_init = 1'b1; idle_inputs();
    @(posedge clock); @(negedge clock);
    reset = 1'b0; mem_init = 1'b0;
    m_busy = 1'b0; m_we = 1'b0; m_port = 0; m_last = 1;
    m_addr = 32'd0; m_wdata = 32'd0;
    m_rdata[0] = 32'd0; m_rdata[1] = 32'd0;
    for (int i = 0; i < 8; i++) m_mem[i] = 32'hA000 + i;
    for (int p = 0; p < 2; p++) begin
      rq[p] = 1'b0; wq[p] = 1'b0; aq[p] = 32'd0; dq[p] = 32'd0;
      e_gnt[p] = 1'b0; e_done[p] = 1'b0;
    end

    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int p = 0; p < 2; p++) begin
        if (!rq[p] || e_gnt[p]) begin
          if ($urandom_range(2) != 0) begin
            rq[p] = 1'b1; wq[p] = 1'($urandom_range(1));
            aq[p] = 32'($urandom_range(7)); dq[p] = $urandom;
          end else begin
            rq[p] = 1'b0;
          end
        end
      end
      req0 = rq[0]; we0 = wq[0]; addr0 = aq[0]; wdata0 = dq[0];
      req1 = rq[1]; we1 = wq[1]; addr1 = aq[1]; wdata1 = dq[1];
      @(posedge clock);
      model_step();
      @(negedge clock);
      checkOutput("rnd_gnt0",  32'(gnt0),  32'(e_gnt[0]));
      checkOutput("rnd_gnt1",  32'(gnt1),  32'(e_gnt[1]));
      checkOutput("rnd_done0", 32'(done0), 32'(e_done[0]));
      checkOutput("rnd_done1", 32'(done1), 32'(e_done[1]));
      checkOutput("rnd_busy",  32'(busy),  32'(m_busy));
      checkOutput("rnd_mem_we", 32'(mem_we), 32'(m_busy & m_we));
      checkOutput("rnd_rdata0", rdata0, m_rdata[0]);
      checkOutput("rnd_rdata1", rdata1, m_rdata[1]);
      checkOutput("rnd_last_port", 32'(last_port), 32'(m_last));
      if (m_busy) checkOutput("rnd_mem_addr", mem_addr, m_addr);
      if (m_busy && m_we) checkOutput("rnd_mem_wdata", mem_wdata, m_wdata);
    end
    idle_inputs();
    rq[0] = 1'b0; rq[1] = 1'b0;
    @(posedge clock);
    model_step();
    @(negedge clock);
    for (int i = 0; i < 8; i++) checkOutput($sformatf("rnd_word%0d", i), dmem[i], m_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
